fp12_requant_pack: RTL and testbench
====================================

FP12_REQUANT_PACK -- requirements
Module: fp12_requant_pack

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 e5m2mode  input  1  target format: 1 = E5M2 (bias 15), 0 = E4M3 (bias 7); sampled per element at accept.
REQ-004 in_valid  input  1  in_data valid.
REQ-005 in_ready  output  1  block can accept in_data this cycle.
REQ-006 in_data  input  12  product word {sign, exp[4:0] bias 15, frac[5:0] with implicit 1}; exp 0 = zero, exp 31 = overflow marker.
REQ-007 in_last  input  1  qualifies accepted element as last of a vector; flushes partial word.
REQ-008 out_valid  output  1  out_data/out_keep valid.
REQ-009 out_ready  input  1  consumer accepts word.
REQ-010 out_data  output  32  four FP8 lanes, lane 0 in [7:0], lane 3 in [31:24].
REQ-011 out_keep  output  4  per-lane valid bits for out_data.
REQ-012 sat_count  output  16  count of saturated conversions, sticks at 0xFFFF.

Function
REQ-013 Accept occurs when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-014 Each accepted element is converted combinationally and written to lane lane_idx (2-bit counter) of a pack buffer; lane_idx increments per accept.
REQ-015 On accept with lane_idx==3 or in_last==1, the completed word loads the output register: out_valid=1 next cycle, out_keep = lanes written (e.g. 0x3 for two), unwritten lanes 0x00; lane_idx returns to 0.
REQ-016 Latency: out_valid rises the cycle after the completing accept; with out_ready held high, sustained throughput is one element per cycle with no bubbles.
REQ-017 out_data/out_keep held stable while out_valid && !out_ready; out_valid clears after handshake unless a new word loads in the same cycle.
REQ-018 Sign always passes through unchanged, including zero and saturated results.
REQ-019 Zero: in exp==0 -> output {sign, 0x00 magnitude} in both modes.
REQ-020 E5M2: exponent kept; frac[5:0] rounded to 2 bits round-to-nearest-even (guard frac[3], sticky |frac[2:0]); mantissa carry increments exponent.
REQ-021 E5M2 saturation: input exp 31, or rounded exponent reaching 31 -> magnitude 0x7B (max finite); no Inf/NaN produced.
REQ-022 E4M3: exponent e4 = exp - 8; exp<=8 (checked before rounding) -> flush to signed zero; frac rounded to 3 bits RNE (guard frac[2], sticky |frac[1:0]); carry increments e4.
REQ-023 E4M3 saturation: input exp 31, e4>15, or result {e4=15, m=111} -> magnitude 0x7E.
REQ-024 Each saturated conversion increments sat_count by 1 on the accept edge, holding at 0xFFFF.
REQ-025 Mode may change between elements of one word; each lane uses the mode sampled at its own accept.

Reset
REQ-026 On rst: out_valid=0, out_data=0, out_keep=0, lane_idx=0, pack buffer cleared, sat_count=0; in_ready=1 the cycle after reset.
REQ-027 rst mid-word discards the partial word; no output is emitted for it.
REQ-028 rst overrides a simultaneous accept or output handshake.

Verification
REQ-029 E4M3, out_ready=1, four elements 0x3C0 -> one word out_data=0x38383838, out_keep=0xF, out_valid one cycle after 4th accept.
REQ-030 E5M2 rounding: 0x3C0->0x3C, 0x3E8 (tie, even)->0x3E, 0x3F8 (tie, odd, carry)->0x40, 0xBD0->0xBD; word 0xBD403E3C.
REQ-031 Saturation: E5M2 0x7C0->0x7B, 0xFC0->0xFB; E4M3 0x5FC->0x7E, 0x7C0->0x7E; sat_count increments by 4.
REQ-032 E4M3 underflow: 0x200->0x00, 0xA00->0x80, sat_count unchanged.
REQ-033 Two E4M3 elements with in_last on second -> out_keep=0x3, out_data[31:16]=0; next element lands in lane 0.
REQ-034 out_ready low for 5 cycles with full word pending -> out_data stable, in_ready=0 after next word completes; rst asserted with lane_idx=2 -> out_valid stays 0, sat_count=0.

Source files
------------

// File: rtl/fp12_requant_pack_if.sv
// rtl/fp12_requant_pack_if.sv - element input / packed-word output bundle for fp12_requant_pack
//
// Purpose: groups the input element handshake, the packed output word
// handshake and the saturation counter of fp12_requant_pack.
// Signals:
//   e5m2mode   target format per element (1 = E5M2, 0 = E4M3)
//   in_valid   in_data valid              in_ready   block can accept
//   in_data    12-bit product word        in_last    last element of vector
//   out_valid  packed word valid          out_ready  consumer accepts word
//   out_data   four FP8 lanes             out_keep   per-lane valid bits
//   sat_count  saturated conversions, sticky at 0xFFFF
// Modports: master drives elements and out_ready; slave is the packer.

interface fp12_requant_pack_if;
    logic        e5m2mode;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic [15:0] sat_count;

    modport master (
        output e5m2mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, sat_count
    );

    modport slave (
        input  e5m2mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, sat_count
    );
endinterface

// File: rtl/fp12_requant_pack.sv
// rtl/fp12_requant_pack.sv - FP12 product to FP8 (E5M2/E4M3) requantizer and 4-lane packer
//
// Purpose: converts each accepted 12-bit product word {sign, exp5 bias 15,
// frac6} to FP8 in the per-element selected format, packs four results per
// 32-bit output word (lane 0 in [7:0]), flushes a partial word on in_last and
// counts saturated conversions.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   fp12_requant_pack_if.slave (element input, word output, sat_count)

module fp12_requant_pack (
    input  logic                   clk,
    input  logic                   rst,
    fp12_requant_pack_if.slave     bus
);

    logic [31:0] r_buf;
    logic [1:0]  r_lane_idx;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [3:0]  r_out_keep;
    logic [15:0] r_sat_count;

    logic        w_accept;
    logic        w_complete;
    logic        w_sign;
    logic [4:0]  w_exp;
    logic [5:0]  w_frac;
    logic        w_up;
    logic [2:0]  w_m5;
    logic [5:0]  w_e5;
    logic [3:0]  w_m4;
    logic [5:0]  w_e4;
    logic [7:0]  w_lane;
    logic        w_sat;
    logic [31:0] w_word;
    logic [3:0]  w_keep;

    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_keep  = r_out_keep;
    assign bus.sat_count = r_sat_count;

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_complete = (r_lane_idx == 2'd3) || bus.in_last;

    assign w_sign = bus.in_data[11];
    assign w_exp  = bus.in_data[10:6];
    assign w_frac = bus.in_data[5:0];

    // Element conversion. Rounding is RNE: round up when guard is set and
    // either sticky or the retained LSB is set (tie goes to even).
    always_comb begin
        w_lane = {w_sign, 7'h00};
        w_sat  = 1'b0;
        w_up   = 1'b0;
        w_m5   = 3'd0;
        w_e5   = 6'd0;
        w_m4   = 4'd0;
        w_e4   = 6'd0;
        if (w_exp == 5'd0) begin
            w_lane = {w_sign, 7'h00};
        end else if (w_exp == 5'd31) begin
            w_sat  = 1'b1;
            w_lane = {w_sign, (bus.e5m2mode ? 7'h7B : 7'h7E)};
        end else if (bus.e5m2mode) begin
            w_up = w_frac[3] && ((|w_frac[2:0]) || w_frac[4]);
            w_m5 = {1'b0, w_frac[5:4]} + {2'b00, w_up};
            w_e5 = {1'b0, w_exp} + {5'd0, w_m5[2]};
            // Exponent 31 is Inf/NaN in E5M2; clamp to max finite instead.
            if (w_e5 >= 6'd31) begin
                w_sat  = 1'b1;
                w_lane = {w_sign, 7'h7B};
            end else begin
                w_lane = {w_sign, w_e5[4:0], w_m5[1:0]};
            end
        end else if (w_exp > 5'd8) begin
            w_up = w_frac[2] && ((|w_frac[1:0]) || w_frac[3]);
            w_m4 = {1'b0, w_frac[5:3]} + {3'b000, w_up};
            w_e4 = {1'b0, w_exp} - 6'd8 + {5'd0, w_m4[3]};
            // E4M3 reserves {1111,111} for NaN, so 0x7E is the largest finite.
            if ((w_e4 > 6'd15) || ((w_e4 == 6'd15) && (w_m4[2:0] == 3'b111))) begin
                w_sat  = 1'b1;
                w_lane = {w_sign, 7'h7E};
            end else begin
                w_lane = {w_sign, w_e4[3:0], w_m4[2:0]};
            end
        end
    end

    // Merge the current element into its lane; lanes above it are still
    // zero because the buffer is cleared whenever a word is emitted.
    always_comb begin
        w_word = r_buf;
        w_keep = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (r_lane_idx == 2'(i)) begin
                w_word[8*i +: 8] = w_lane;
            end
            w_keep[i] = (2'(i) <= r_lane_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf       <= 32'd0;
            r_lane_idx  <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_keep  <= 4'h0;
            r_sat_count <= 16'd0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_buf      <= 32'd0;
                    r_lane_idx <= 2'd0;
                end else begin
                    r_buf      <= w_word;
                    r_lane_idx <= r_lane_idx + 2'd1;
                end
            end
            // A load can only happen when the output slot is free or being
            // drained this cycle, so it always takes priority over clearing.
            if (w_accept && w_complete) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_keep  <= w_keep;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && w_sat && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fp12_requant_pack.sv
// tb/tb_fp12_requant_pack.sv - directed self-checking bench for fp12_requant_pack

module tb_fp12_requant_pack;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fp12_requant_pack_if bus();

    fp12_requant_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present one element for one clock edge; returns 1 time unit after it.
    task automatic push(input logic [11:0] d, input logic mode, input logic last);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.e5m2mode = mode;
        bus.in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 12'h000;
        bus.in_last   = 1'b0;
        bus.e5m2mode  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_keep", 32'(bus.out_keep), 32'd0);
        chk("rst_sat_count", 32'(bus.sat_count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // E4M3 full word, latency one cycle after the 4th accept
        push(12'h3C0, 1'b0, 1'b0);
        push(12'h3C0, 1'b0, 1'b0);
        push(12'h3C0, 1'b0, 1'b0);
        chk("e4_no_early_valid", 32'(bus.out_valid), 32'd0);
        push(12'h3C0, 1'b0, 1'b0);
        chk("e4_word_valid", 32'(bus.out_valid), 32'd1);
        chk("e4_word_data", bus.out_data, 32'h38383838);
        chk("e4_word_keep", 32'(bus.out_keep), 32'hF);

        // E5M2 rounding cases, back-to-back after the previous word
        push(12'h3C0, 1'b1, 1'b0);
        chk("e4_word_drained", 32'(bus.out_valid), 32'd0);
        push(12'h3E8, 1'b1, 1'b0);
        push(12'h3F8, 1'b1, 1'b0);
        push(12'hBD0, 1'b1, 1'b0);
        chk("e5_round_valid", 32'(bus.out_valid), 32'd1);
        chk("e5_round_data", bus.out_data, 32'hBD403E3C);
        chk("e5_round_keep", 32'(bus.out_keep), 32'hF);

        // Saturation in both modes, mode switching inside one word
        push(12'h7C0, 1'b1, 1'b0);
        push(12'hFC0, 1'b1, 1'b0);
        push(12'h5FC, 1'b0, 1'b0);
        push(12'h7C0, 1'b0, 1'b0);
        chk("sat_data", bus.out_data, 32'h7E7EFB7B);
        chk("sat_count4", 32'(bus.sat_count), 32'd4);

        // E4M3 underflow flushes to signed zero, partial word via in_last
        push(12'h200, 1'b0, 1'b0);
        push(12'hA00, 1'b0, 1'b1);
        chk("uflow_data", bus.out_data, 32'h00008000);
        chk("uflow_keep", 32'(bus.out_keep), 32'h3);
        chk("uflow_sat_count", 32'(bus.sat_count), 32'd4);

        // Two-element word, then a single element must land in lane 0
        push(12'h3C0, 1'b0, 1'b0);
        push(12'hBC0, 1'b0, 1'b1);
        chk("two_data", bus.out_data, 32'h0000B838);
        chk("two_keep", 32'(bus.out_keep), 32'h3);
        push(12'h3C0, 1'b0, 1'b1);
        chk("one_data", bus.out_data, 32'h00000038);
        chk("one_keep", 32'(bus.out_keep), 32'h1);

        // E4M3 rounding tie/up and smallest normal exponent, three lanes
        push(12'h3C4, 1'b0, 1'b0);
        push(12'h3CC, 1'b0, 1'b0);
        push(12'h240, 1'b0, 1'b1);
        chk("e4_round_data", bus.out_data, 32'h00083A38);
        chk("e4_round_keep", 32'(bus.out_keep), 32'h7);
        idle();
        chk("idle_valid_clear", 32'(bus.out_valid), 32'd0);

        // Backpressure: word held stable, input stalled
        bus.out_ready = 1'b0;
        push(12'h3C0, 1'b0, 1'b0);
        push(12'h3C0, 1'b0, 1'b0);
        push(12'h3C0, 1'b0, 1'b0);
        push(12'hBC0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_data", bus.out_data, 32'hB8383838);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_released", 32'(bus.out_valid), 32'd0);

        // Reset mid-word (lane_idx == 2) overriding a completing saturating accept
        push(12'h3C0, 1'b1, 1'b0);
        push(12'h3E8, 1'b1, 1'b0);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'h7C0;
        bus.e5m2mode = 1'b1;
        bus.in_last  = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_sat", 32'(bus.sat_count), 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_no_word", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        push(12'h3C0, 1'b1, 1'b1);
        chk("post_rst_data", bus.out_data, 32'h0000003C);
        chk("post_rst_keep", 32'(bus.out_keep), 32'h1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
